// File: rtl/usb_phy_pkg.sv
// Shared USB PHY types and constants: line-state encodings, bus state enum and
// 60 MHz default timing for the bus event detector.
package usb_phy_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [1:0] {
    BUS_ACTIVE  = 2'b00,
    BUS_RESET   = 2'b01,
    BUS_SUSPEND = 2'b10,
    BUS_RESUME  = 2'b11
  } bus_state_t;

  // 2.5 us and 3 ms at 60 MHz
  localparam int DEF_RESET_CYCLES   = 150;
  localparam int DEF_SUSPEND_CYCLES = 180000;
  localparam int DEF_RESUME_CYCLES  = 150;
  localparam int DEF_CNT_W          = 18;

endpackage

// File: rtl/usb_run_length_counter.sv
// Previous-sample register plus saturating run-length counter for the line state.
// o_count is the zero-based position of the current sample within its run.
module usb_run_length_counter
  import usb_phy_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_line_state,
  output logic             o_same,
  output logic [CNT_W-1:0] o_count
);

  logic [1:0]       prev_q;
  logic [CNT_W-1:0] cnt_q;

  assign o_same = (i_line_state == prev_q);

  always_comb begin
    o_count = '0;
    if (o_same) begin
      o_count = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q <= LS_J;
      cnt_q  <= '0;
    end else begin
      prev_q <= i_line_state;
      cnt_q  <= o_count;
    end
  end

endmodule

// File: rtl/usb_bus_event_detector.sv
// USB bus event detector: times line-state runs to flag bus reset, suspend,
// resume and HS idle timeout. Optional SE1 error flag under BUS_EVT_SE1_ERR_EN.
//
// state       | meaning
// BUS_ACTIVE  | normal traffic; watching for SE0 reset, J idle, HS SE0 timeout
// BUS_RESET   | SE0 held long enough; leave on first non-SE0 sample
// BUS_SUSPEND | J idle held long enough; K resumes, SE0 resets
// BUS_RESUME  | K resume signalling; leave on first non-K sample
module usb_bus_event_detector
  import usb_phy_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES,
  parameter int RESUME_CYCLES  = DEF_RESUME_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_line_state,
  input  logic       i_hs_mode,
  output logic [1:0] o_bus_state,
  output logic       o_bus_reset,
  output logic       o_reset_pulse,
  output logic       o_suspend,
  output logic       o_resume_pulse,
  output logic       o_hs_timeout,
  output logic       o_se1_err
);

  localparam logic [CNT_W-1:0] RESET_TC   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SUSPEND_TC = CNT_W'(SUSPEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESUME_TC  = CNT_W'(RESUME_CYCLES - 1);

  bus_state_t       state_q;
  logic             same;
  logic [CNT_W-1:0] count;
  logic             se0_reset_hit;
  logic             se0_idle_hit;
  logic             j_idle_hit;
  logic             k_resume_hit;
  logic             enter_reset;

  usb_run_length_counter #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_line_state (i_line_state),
    .o_same       (same),
    .o_count      (count)
  );

  // Exact-equality compares fire once per run; a saturated count never re-fires.
  assign se0_reset_hit = same && (i_line_state == LS_SE0) && (count == RESET_TC);
  assign se0_idle_hit  = same && (i_line_state == LS_SE0) && (count == SUSPEND_TC);
  assign j_idle_hit    = same && (i_line_state == LS_J)   && (count == SUSPEND_TC);
  assign k_resume_hit  = same && (i_line_state == LS_K)   && (count == RESUME_TC);

  assign enter_reset = se0_reset_hit &&
                       (((state_q == BUS_ACTIVE) && !i_hs_mode) || (state_q == BUS_SUSPEND));

  assign o_bus_state = state_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= BUS_ACTIVE;
      o_bus_reset    <= 1'b0;
      o_reset_pulse  <= 1'b0;
      o_suspend      <= 1'b0;
      o_resume_pulse <= 1'b0;
      o_hs_timeout   <= 1'b0;
    end else begin
      o_reset_pulse  <= 1'b0;
      o_resume_pulse <= 1'b0;
      o_hs_timeout   <= 1'b0;
      case (state_q)
        BUS_ACTIVE: begin
          if (enter_reset) begin
            state_q       <= BUS_RESET;
            o_bus_reset   <= 1'b1;
            o_reset_pulse <= 1'b1;
          end else if (!i_hs_mode && j_idle_hit) begin
            state_q   <= BUS_SUSPEND;
            o_suspend <= 1'b1;
          end else if (i_hs_mode && se0_idle_hit) begin
            o_hs_timeout <= 1'b1;
          end
        end
        BUS_RESET: begin
          if (i_line_state != LS_SE0) begin
            state_q     <= BUS_ACTIVE;
            o_bus_reset <= 1'b0;
          end
        end
        BUS_SUSPEND: begin
          if (enter_reset) begin
            state_q       <= BUS_RESET;
            o_suspend     <= 1'b0;
            o_bus_reset   <= 1'b1;
            o_reset_pulse <= 1'b1;
          end else if (k_resume_hit) begin
            state_q        <= BUS_RESUME;
            o_suspend      <= 1'b0;
            o_resume_pulse <= 1'b1;
          end
        end
        BUS_RESUME: begin
          if (i_line_state != LS_K) begin
            state_q <= BUS_ACTIVE;
          end
        end
        default: begin
          state_q <= BUS_ACTIVE;
        end
      endcase
    end
  end

`ifdef BUS_EVT_SE1_ERR_EN
  // Sticky until the next bus reset; SE1 never changes the bus state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_se1_err <= 1'b0;
    end else if (enter_reset) begin
      o_se1_err <= 1'b0;
    end else if (same && (i_line_state == LS_SE1)) begin
      o_se1_err <= 1'b1;
    end
  end
`else
  assign o_se1_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_bus_event_detector.sv
// Directed bench for usb_bus_event_detector with shortened thresholds (4/16/3).
module tb_usb_bus_event_detector;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] line = J;
  logic       hs = 1'b0;
  logic [1:0] bus_state;
  logic       bus_reset, reset_pulse, suspend, resume_pulse, hs_timeout, se1_err;

  int errors = 0;
  int checks = 0;

  usb_bus_event_detector #(
    .RESET_CYCLES   (4),
    .SUSPEND_CYCLES (16),
    .RESUME_CYCLES  (3),
    .CNT_W          (18)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_line_state   (line),
    .i_hs_mode      (hs),
    .o_bus_state    (bus_state),
    .o_bus_reset    (bus_reset),
    .o_reset_pulse  (reset_pulse),
    .o_suspend      (suspend),
    .o_resume_pulse (resume_pulse),
    .o_hs_timeout   (hs_timeout),
    .o_se1_err      (se1_err)
  );

  always #5 clk = ~clk;

  // Present one sample, let it be clocked, then look just after the edge.
  task automatic drive(input logic [1:0] ls);
    line = ls;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; line = J; hs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus_state, bus_reset, reset_pulse, suspend, resume_pulse, hs_timeout, se1_err} !== 8'h00)
      begin errors++; $display("FAIL reset_outputs: got %b expected 00000000",
        {bus_state, bus_reset, reset_pulse, suspend, resume_pulse, hs_timeout, se1_err}); end
    rst = 1'b0;
    drive(K);
    checks++;
    if (bus_state !== 2'b00) begin errors++; $display("FAIL reset_release_state: got %b expected 00", bus_state); end
  endtask

  task automatic test_reset_mid_run;
    repeat (3) drive(SE0);
    rst = 1'b1;
    #2;
    checks++;
    if ({bus_state, bus_reset, reset_pulse} !== 4'b0000) begin errors++;
      $display("FAIL midrun_async_clear: got %b expected 0000", {bus_state, bus_reset, reset_pulse}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) drive(SE0);
    checks++;
    if (reset_pulse !== 1'b0 || bus_reset !== 1'b0) begin errors++;
      $display("FAIL midrun_fresh_count3: got pulse=%b lvl=%b expected 0 0", reset_pulse, bus_reset); end
    drive(SE0);
    checks++;
    if (reset_pulse !== 1'b1 || bus_reset !== 1'b1) begin errors++;
      $display("FAIL midrun_fresh_count4: got pulse=%b lvl=%b expected 1 1", reset_pulse, bus_reset); end
    drive(SE0);
    rst = 1'b1;
    #2;
    checks++;
    if (bus_reset !== 1'b0 || bus_state !== 2'b00) begin errors++;
      $display("FAIL reset_state_async_clear: got lvl=%b state=%b expected 0 00", bus_reset, bus_state); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(J);
  endtask

  task automatic test_fs_reset;
    logic seen;
    drive(J); drive(J);
    repeat (3) drive(SE0);
    checks++;
    if (reset_pulse !== 1'b0) begin errors++; $display("FAIL fs_reset_early: got %b expected 0", reset_pulse); end
    drive(SE0);
    checks++;
    if ({reset_pulse, bus_reset, bus_state} !== 4'b1101) begin errors++;
      $display("FAIL fs_reset_entry: got %b expected 1101", {reset_pulse, bus_reset, bus_state}); end
    drive(SE0);
    checks++;
    if ({reset_pulse, bus_reset, bus_state} !== 4'b0101) begin errors++;
      $display("FAIL fs_reset_pulse_width: got %b expected 0101", {reset_pulse, bus_reset, bus_state}); end
    drive(J);
    checks++;
    if ({bus_reset, bus_state} !== 3'b000) begin errors++;
      $display("FAIL fs_reset_exit: got %b expected 000", {bus_reset, bus_state}); end
    seen = 1'b0;
    repeat (3) begin drive(SE0); seen = seen | bus_reset | reset_pulse; end
    drive(J);
    seen = seen | bus_reset | reset_pulse;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL fs_short_se0: got event=%b expected 0", seen); end
  endtask

  task automatic test_suspend_resume;
    drive(K);
    repeat (15) drive(J);
    checks++;
    if ({suspend, bus_state} !== 3'b000) begin errors++;
      $display("FAIL suspend_early: got %b expected 000", {suspend, bus_state}); end
    drive(J);
    checks++;
    if ({suspend, bus_state} !== 3'b110) begin errors++;
      $display("FAIL suspend_entry: got %b expected 110", {suspend, bus_state}); end
    drive(K); drive(K);
    checks++;
    if ({resume_pulse, suspend, bus_state} !== 4'b0110) begin errors++;
      $display("FAIL resume_early: got %b expected 0110", {resume_pulse, suspend, bus_state}); end
    drive(K);
    checks++;
    if ({resume_pulse, suspend, bus_state} !== 4'b1011) begin errors++;
      $display("FAIL resume_entry: got %b expected 1011", {resume_pulse, suspend, bus_state}); end
    drive(K);
    checks++;
    if ({resume_pulse, bus_state} !== 3'b011) begin errors++;
      $display("FAIL resume_pulse_width: got %b expected 011", {resume_pulse, bus_state}); end
    drive(SE0);
    checks++;
    if (bus_state !== 2'b00) begin errors++; $display("FAIL resume_exit: got %b expected 00", bus_state); end
    drive(J);
  endtask

  task automatic test_reset_from_suspend;
    drive(K);
    repeat (16) drive(J);
    drive(SE1);
    drive(J);
    checks++;
    if ({suspend, bus_state} !== 3'b110) begin errors++;
      $display("FAIL suspend_hold_se1_j: got %b expected 110", {suspend, bus_state}); end
    repeat (3) drive(SE0);
    checks++;
    if ({suspend, reset_pulse} !== 2'b10) begin errors++;
      $display("FAIL susp_reset_early: got %b expected 10", {suspend, reset_pulse}); end
    drive(SE0);
    checks++;
    if ({suspend, reset_pulse, bus_reset, bus_state} !== 5'b01101) begin errors++;
      $display("FAIL susp_reset_entry: got %b expected 01101", {suspend, reset_pulse, bus_reset, bus_state}); end
    drive(J);
  endtask

  task automatic test_hs_idle;
    int pulses;
    int at_step;
    logic any_reset;
    pulses = 0; at_step = -1; any_reset = 1'b0;
    hs = 1'b1;
    drive(J);
    for (int s = 1; s <= 20; s++) begin
      drive(SE0);
      if (hs_timeout === 1'b1) begin pulses++; at_step = s; end
      any_reset = any_reset | bus_reset | reset_pulse;
    end
    checks++;
    if (pulses != 1 || at_step != 16) begin errors++;
      $display("FAIL hs_timeout_pulse: got count=%0d step=%0d expected 1 16", pulses, at_step); end
    checks++;
    if (any_reset !== 1'b0 || bus_state !== 2'b00) begin errors++;
      $display("FAIL hs_no_reset: got reset=%b state=%b expected 0 00", any_reset, bus_state); end
    hs = 1'b0;
    drive(J);
  endtask

  task automatic test_mode_change;
    hs = 1'b1;
    drive(J);
    repeat (3) drive(SE0);
    hs = 1'b0;
    drive(SE0);
    checks++;
    if ({reset_pulse, bus_state} !== 3'b101) begin errors++;
      $display("FAIL mode_change_run_kept: got %b expected 101", {reset_pulse, bus_state}); end
    drive(J);
  endtask

  task automatic test_se1;
`ifdef BUS_EVT_SE1_ERR_EN
    drive(J);
    drive(SE1);
    checks++;
    if (se1_err !== 1'b0) begin errors++; $display("FAIL se1_single: got %b expected 0", se1_err); end
    drive(SE1);
    checks++;
    if (se1_err !== 1'b1) begin errors++; $display("FAIL se1_set: got %b expected 1", se1_err); end
    repeat (3) drive(J);
    checks++;
    if ({se1_err, bus_state} !== 3'b100) begin errors++;
      $display("FAIL se1_sticky: got %b expected 100", {se1_err, bus_state}); end
    repeat (4) drive(SE0);
    checks++;
    if ({se1_err, reset_pulse} !== 2'b01) begin errors++;
      $display("FAIL se1_clear_on_reset: got %b expected 01", {se1_err, reset_pulse}); end
    drive(J);
`else
    logic seen;
    seen = 1'b0;
    drive(J);
    repeat (3) begin drive(SE1); seen = seen | se1_err; end
    drive(J);
    checks++;
    if (seen !== 1'b0 || bus_state !== 2'b00) begin errors++;
      $display("FAIL se1_disabled: got err=%b state=%b expected 0 00", seen, bus_state); end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_fs_reset();
    test_suspend_resume();
    test_reset_from_suspend();
    test_hs_idle();
    test_mode_change();
    test_se1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
